stability_indicator_ctrl: RTL and testbench

//   Drives the color_sel[2:0] / blink_en command pair that the 4x RGB LED driver consumes.

---
 rtl/stability_indicator_ctrl_if.sv | 21 ++
 rtl/stability_indicator_ctrl.sv | 170 +++++++++++++++++
 tb/tb_stability_indicator_ctrl.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/stability_indicator_ctrl_if.sv
// Bundle between the system monitor / LED driver side and the stability indicator controller.
// The master side drives the raw level and event strobes and consumes the LED command.
interface stability_indicator_ctrl_if;
  logic [1:0] level_in;
  logic       event_pulse;
  logic       fault_clr;
  logic [2:0] color_sel;
  logic       blink_en;
  logic       event_active;
  logic       fault_o;

  modport master (
    output level_in, event_pulse, fault_clr,
    input  color_sel, blink_en, event_active, fault_o
  );

  modport slave (
    input  level_in, event_pulse, fault_clr,
    output color_sel, blink_en, event_active, fault_o
  );
endinterface

// File: rtl/stability_indicator_ctrl.sv
// Stability LED controller: debounced level -> colour, timed event flash, fault override.
// Define STAB_IND_FAULT_LATCH_EN to make the fault state sticky until fault_clr.
//   state     | meaning
//   ST_NORMAL | colour follows the filtered level
//   ST_EVENT  | white blinking flash, ev_cnt counts the remaining dwell
//   ST_FAULT  | red blinking, overrides everything
module stability_indicator_ctrl #(
  parameter int unsigned LEVEL_HOLD = 50000,
  parameter int unsigned EVENT_HOLD = 100000000
) (
  input  logic                        clk,
  input  logic                        rst_n,
  stability_indicator_ctrl_if.slave   bus
);

  localparam int LV_W = $clog2(LEVEL_HOLD + 1);
  localparam int EV_W = $clog2(EVENT_HOLD + 1);
  localparam logic [LV_W-1:0] LV_MAX    = LV_W'(LEVEL_HOLD);
  localparam logic [EV_W-1:0] EV_RELOAD = EV_W'(EVENT_HOLD - 1);

  typedef enum logic [1:0] {
    ST_NORMAL = 2'd0,
    ST_EVENT  = 2'd1,
    ST_FAULT  = 2'd2
  } state_e;

  logic [1:0]      cand_q, cand_d;
  logic [LV_W-1:0] cnt_q, cnt_d;
  logic [1:0]      lvl_q, lvl_d;
  state_e          state_q, state_d;
  logic [EV_W-1:0] ev_cnt_q, ev_cnt_d;
  logic [2:0]      color_q, color_d;
  logic            blink_q, blink_d;
  logic            ev_act_q, ev_act_d;
  logic            fault_q, fault_d;
  logic            fault_lvl;

`ifndef STAB_IND_FAULT_LATCH_EN
  logic unused_fault_clr;
  assign unused_fault_clr = bus.fault_clr;
`endif

  // Level filter: count consecutive equal samples, saturating at LEVEL_HOLD.
  always_comb begin
    cand_d = cand_q;
    cnt_d  = cnt_q;
    lvl_d  = lvl_q;
    if (bus.level_in != cand_q) begin
      cand_d = bus.level_in;
      cnt_d  = LV_W'(1);
    end else if ((cand_q != lvl_q) && (cnt_q != LV_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
    if ((cand_d != lvl_q) && (cnt_d == LV_MAX)) begin
      lvl_d = cand_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand_q <= 2'd0;
      cnt_q  <= '0;
      lvl_q  <= 2'd0;
    end else begin
      cand_q <= cand_d;
      cnt_q  <= cnt_d;
      lvl_q  <= lvl_d;
    end
  end

  // The FSM looks at the level being adopted on this edge, so fault entry/exit
  // lines up with the colour latency and a same-edge event cannot flash first.
  assign fault_lvl = (lvl_d == 2'd3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_NORMAL;
      ev_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      ev_cnt_q <= ev_cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ev_cnt_d = ev_cnt_q;
    case (state_q)
      ST_NORMAL: begin
        if (fault_lvl) begin
          state_d = ST_FAULT;
        end else if (bus.event_pulse) begin
          state_d  = ST_EVENT;
          ev_cnt_d = EV_RELOAD;
        end
      end
      ST_EVENT: begin
        if (fault_lvl) begin
          state_d = ST_FAULT;
        end else if (bus.event_pulse) begin
          ev_cnt_d = EV_RELOAD;
        end else if (ev_cnt_q == '0) begin
          state_d = ST_NORMAL;
        end else begin
          ev_cnt_d = ev_cnt_q - 1'b1;
        end
      end
      ST_FAULT: begin
`ifdef STAB_IND_FAULT_LATCH_EN
        if (bus.fault_clr && !fault_lvl) begin
          state_d = ST_NORMAL;
        end
`else
        if (!fault_lvl) begin
          state_d = ST_NORMAL;
        end
`endif
      end
      default: state_d = ST_NORMAL;
    endcase
  end

  always_comb begin
    color_d  = 3'b000;
    blink_d  = 1'b0;
    ev_act_d = (state_q == ST_EVENT);
    fault_d  = (state_q == ST_FAULT);
    case (state_q)
      ST_EVENT: begin
        color_d = 3'b111;
        blink_d = 1'b1;
      end
      ST_FAULT: begin
        color_d = 3'b100;
        blink_d = 1'b1;
      end
      default: begin
        case (lvl_q)
          2'd0:    color_d = 3'b010;
          2'd1:    color_d = 3'b110;
          2'd2:    color_d = 3'b100;
          default: begin
            color_d = 3'b100;
            blink_d = 1'b1;
          end
        endcase
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      color_q  <= 3'b000;
      blink_q  <= 1'b0;
      ev_act_q <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      color_q  <= color_d;
      blink_q  <= blink_d;
      ev_act_q <= ev_act_d;
      fault_q  <= fault_d;
    end
  end

  assign bus.color_sel    = color_q;
  assign bus.blink_en     = blink_q;
  assign bus.event_active = ev_act_q;
  assign bus.fault_o      = fault_q;

endmodule

// File: tb/tb_stability_indicator_ctrl.sv
// Directed bench for stability_indicator_ctrl with LEVEL_HOLD=4, EVENT_HOLD=8.
// Expected output words go through a scoreboard queue; every checked cycle pops one entry.
module tb_stability_indicator_ctrl;

  logic clk;
  logic rst_n;

  stability_indicator_ctrl_if bus_if ();

  stability_indicator_ctrl #(
    .LEVEL_HOLD (4),
    .EVENT_HOLD (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic [5:0] word;   // {color_sel, blink_en, event_active, fault_o}
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_mis = 0;

  localparam logic [5:0] W_RST  = 6'b000_0_0_0;
  localparam logic [5:0] W_GRN  = 6'b010_0_0_0;
  localparam logic [5:0] W_YEL  = 6'b110_0_0_0;
  localparam logic [5:0] W_EVT  = 6'b111_1_1_0;
  localparam logic [5:0] W_FLT  = 6'b100_1_0_1;

  task automatic push(input string tag, input logic [5:0] w);
    exp_t e;
    e.tag  = tag;
    e.word = w;
    sb.push_back(e);
  endtask

  task automatic pop_check();
    exp_t       e;
    logic [5:0] obs;
    e   = sb.pop_front();
    obs = {bus_if.color_sel, bus_if.blink_en, bus_if.event_active, bus_if.fault_o};
    n_cmp++;
    assert (obs === e.word) else begin
      n_mis++;
      $error("FAIL %s observed=%b expected=%b", e.tag, obs, e.word);
    end
  endtask

  task automatic check_now(input string tag, input logic [5:0] w);
    push(tag, w);
    pop_check();
  endtask

  task automatic run(input int n, input string tag, input logic [5:0] w);
    for (int i = 0; i < n; i++) begin
      push(tag, w);
      @(posedge clk);
      #1;
      pop_check();
    end
  endtask

  task automatic leave_fault(input string tag);
    bus_if.level_in = 2'd0;
    run(4, {tag, "_hold"}, W_FLT);
`ifdef STAB_IND_FAULT_LATCH_EN
    run(3, {tag, "_sticky"}, W_FLT);
    bus_if.fault_clr = 1'b1;
    run(1, {tag, "_clr_edge"}, W_FLT);
    bus_if.fault_clr = 1'b0;
`endif
    run(2, {tag, "_exit"}, W_GRN);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n              = 1'b0;
    bus_if.level_in    = 2'd0;
    bus_if.event_pulse = 1'b0;
    bus_if.fault_clr   = 1'b0;
    #12;
    check_now("reset", W_RST);
    @(negedge clk);
    rst_n = 1'b1;
    run(1, "release", W_GRN);
    run(2, "idle_green", W_GRN);

    // glitch one sample short of the hold time
    bus_if.level_in = 2'd2;
    run(3, "glitch", W_GRN);
    bus_if.level_in = 2'd0;
    run(6, "glitch_after", W_GRN);

    bus_if.level_in = 2'd1;
    run(4, "deb_wait", W_GRN);
    run(1, "deb_adopt", W_YEL);
    run(2, "deb_stable", W_YEL);

    bus_if.event_pulse = 1'b1;
    run(1, "ev_sample", W_YEL);
    bus_if.event_pulse = 1'b0;
    run(8, "ev_flash", W_EVT);
    run(3, "ev_done", W_YEL);

    bus_if.event_pulse = 1'b1;
    run(1, "ext_sample", W_YEL);
    bus_if.event_pulse = 1'b0;
    run(4, "ext_first", W_EVT);
    bus_if.event_pulse = 1'b1;
    run(1, "ext_reload", W_EVT);
    bus_if.event_pulse = 1'b0;
    run(8, "ext_tail", W_EVT);
    run(2, "ext_done", W_YEL);

    bus_if.level_in = 2'd3;
    run(4, "flt_wait", W_YEL);
    run(2, "flt_enter", W_FLT);
    bus_if.event_pulse = 1'b1;
    run(1, "flt_ev_drop", W_FLT);
    bus_if.event_pulse = 1'b0;
    run(3, "flt_ev_after", W_FLT);
    bus_if.fault_clr = 1'b1;
    run(1, "flt_clr_lvl3", W_FLT);
    bus_if.fault_clr = 1'b0;
    run(2, "flt_clr_after", W_FLT);
    leave_fault("flt");

    // event strobe on the very edge the filter adopts level 3
    bus_if.level_in = 2'd3;
    run(3, "sim_wait", W_GRN);
    bus_if.event_pulse = 1'b1;
    run(1, "sim_edge", W_GRN);
    bus_if.event_pulse = 1'b0;
    run(3, "sim_fault", W_FLT);
    leave_fault("sim");

    bus_if.event_pulse = 1'b1;
    run(1, "mid_sample", W_GRN);
    bus_if.event_pulse = 1'b0;
    run(3, "mid_flash", W_EVT);
    rst_n = 1'b0;
    #1;
    check_now("mid_rst_async", W_RST);
    @(posedge clk);
    #1;
    check_now("mid_rst_hold", W_RST);
    @(negedge clk);
    rst_n = 1'b1;
    run(1, "mid_release", W_GRN);
    run(8, "mid_no_flash", W_GRN);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
